// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand mux selects and
// hazard-detect FSM states.
package fwd_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } hd_state_t;

endpackage

// File: rtl/fwd_hazard_unit_fwd_sel_logic.sv
// Forward select for one EX operand: compares its source index against the
// MEM and WB producers, MEM taking priority. Register 0 never forwards.
module fwd_sel_logic
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  rs_used,
  input  logic                  mem_valid,
  input  logic                  mem_rd_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_rd_we,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs_used && (rs != '0)) begin
      if (mem_valid && mem_rd_we && (mem_rd == rs)) begin
        sel = FWD_EXMEM;
      end else if (wb_valid && wb_rd_we && (wb_rd == rs)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a 5-stage pipeline: tracks the
// EX/MEM/WB occupants and drives operand selects, stall and bubble.
//
// state       | meaning
// ST_RUN      | normal issue; a load-use hazard inserts one bubble
// ST_LU_STALL | bubble inserted last cycle; consumer proceeds next
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic                  mem_ready,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  freeze
);

  logic                  ex_valid, ex_rd_we, ex_is_load, ex_rs1_used, ex_rs2_used;
  logic [REG_ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2;
  logic                  mem_valid, mem_rd_we;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  wb_valid, wb_rd_we;
  logic [REG_ADDR_W-1:0] wb_rd;

  hd_state_t state;
  logic      load_use, stall;
  logic [1:0] sel_a, sel_b;

  assign freeze = !mem_ready;

  assign load_use = id_valid && ex_valid && ex_is_load && ex_rd_we && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // Only RUN may raise a stall, so one hazard yields exactly one bubble.
  assign stall       = !rst && !freeze && !flush && (state == ST_RUN) && load_use;
  assign stall_if_id = stall;
  assign bubble_ex   = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else if (!freeze) begin
      if (stall) state <= ST_LU_STALL;
      else       state <= ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      ex_rd_we    <= 1'b0;
      ex_is_load  <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
      mem_valid   <= 1'b0;
      mem_rd      <= '0;
      mem_rd_we   <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_rd_we    <= 1'b0;
    end else if (!freeze) begin
      wb_valid  <= mem_valid;
      wb_rd     <= mem_rd;
      wb_rd_we  <= mem_rd_we;
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_rd_we <= ex_rd_we;
      if (stall || flush || !id_valid) begin
        ex_valid    <= 1'b0;
        ex_rd       <= '0;
        ex_rd_we    <= 1'b0;
        ex_is_load  <= 1'b0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rs1_used <= 1'b0;
        ex_rs2_used <= 1'b0;
      end else begin
        ex_valid    <= 1'b1;
        ex_rd       <= id_rd;
        ex_rd_we    <= id_rd_we;
        ex_is_load  <= id_is_load;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rs1_used <= id_rs1_used;
        ex_rs2_used <= id_rs2_used;
      end
    end
  end

  fwd_sel_logic #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .rs        (ex_rs1),
    .rs_used   (ex_rs1_used),
    .mem_valid (mem_valid),
    .mem_rd_we (mem_rd_we),
    .mem_rd    (mem_rd),
    .wb_valid  (wb_valid),
    .wb_rd_we  (wb_rd_we),
    .wb_rd     (wb_rd),
    .sel       (sel_a)
  );

  fwd_sel_logic #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .rs        (ex_rs2),
    .rs_used   (ex_rs2_used),
    .mem_valid (mem_valid),
    .mem_rd_we (mem_rd_we),
    .mem_rd    (mem_rd),
    .wb_valid  (wb_valid),
    .wb_rd_we  (wb_rd_we),
    .wb_rd     (wb_rd),
    .sel       (sel_b)
  );

  // Slots are unknown until the first reset edge, so selects are forced clean.
  assign fwd_sel_a = rst ? FWD_RF : sel_a;
  assign fwd_sel_b = rst ? FWD_RF : sel_b;

endmodule
